alu_seq_6502: RTL and testbench
===============================

ALU_SEQ_6502 -- requirements
Module: alu_seq_6502

Interface
Parameters: none.
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  command valid; start_ready  out  1  command accepted when start & start_ready at a rising edge.
REQ-004 cmd_div  in  1  0 = multiply, 1 = divide; opa  in  8  multiplicand/dividend; opb  in  8  multiplier/divisor.
REQ-005 res_valid  out  1, res_ready  in  1, res  out  16: multiply {hi,lo}; divide {remainder,quotient}.
REQ-006 busy  out  1  high whenever the sequencer owns the ALU (states ADD..COMMIT).
REQ-007 cpu_op  in  4, cpu_right  in  1, cpu_ai  in  8, cpu_bi  in  8, cpu_ci  in  1, cpu_bcd  in  1, cpu_rdy  in  1: CPU-side ALU request.
REQ-008 alu_op  out  4, alu_right  out  1, alu_ai  out  8, alu_bi  out  8, alu_ci  out  1, alu_bcd  out  1, alu_rdy  out  1: drive the shared ALU.
REQ-009 alu_out  in  8, alu_co  in  1: registered ALU result, valid one cycle after issue with alu_rdy high.

Function
REQ-010 States: IDLE, ADD, ROR, SHIFT (multiply); SHL, SUB, COMMIT (divide); DONE.
REQ-011 IDLE and DONE: alu_* = cpu_* pass-through, busy=0; all other states: sequencer drives alu_*, alu_bcd=0, busy=1.
REQ-012 start_ready=1 only in IDLE; accept loads A=opa, B=opb, P=0x00, goes to ADD (mul) or SHL (div); start ignored elsewhere.
REQ-013 ADD: alu_ai=P, alu_bi=B, alu_ci=0, alu_right=0, alu_op=0011 if M[0] else 1111; alu_rdy=1; M=A initially.
REQ-014 ROR: alu_op=1111, alu_right=1, alu_ai=alu_out, alu_ci=alu_co, alu_rdy=1.
REQ-015 SHIFT: alu_rdy=0; P<=alu_out, M<={alu_co,M[7:1]}; iteration count +1; to ADD, or DONE after 8th iteration.
REQ-016 SHL: alu_op=1011, alu_ai=R, alu_ci=Q[7], alu_right=0, alu_rdy=1 (R=0, Q=opa at accept).
REQ-017 SUB: registers Rs<=alu_out, c9<=alu_co; issues alu_op=0111, alu_ai=alu_out, alu_bi=B, alu_ci=1, alu_rdy=1.
REQ-018 COMMIT: alu_rdy=0; ok=c9|alu_co; R<=ok?alu_out:Rs; Q<={Q[6:0],ok}; to SHL, or DONE after 8th iteration.
REQ-019 Latency: res_valid rises exactly 24 rising edges after the accepting edge (8 iterations x 3 cycles), either command.
REQ-020 DONE: res_valid=1, res stable until res_valid & res_ready edge, then IDLE; res_ready low holds DONE indefinitely.
REQ-021 start_ready=0 in DONE; a new command is accepted no earlier than the cycle after the result handshake.
REQ-022 Divide by zero: no special case; result quotient=0xFF, remainder=opa.
REQ-023 res is 16-bit unsigned, no overflow possible; res undefined-free: holds last result outside DONE.
REQ-024 cpu_* changes while busy are ignored; CPU is required to stall on busy.

Reset
REQ-025 reset asserted: state=IDLE immediately; start_ready=1 after release, res_valid=0, busy=0, res=0x0000, P/M/R/Q/counter=0.
REQ-026 reset mid-operation aborts without result; no res_valid pulse follows.

Configuration
REQ-027 Macro ALU_SEQ_DIV_EN defined: divide states and cmd_div=1 behaviour per REQ-016..018, REQ-022.
REQ-028 ALU_SEQ_DIV_EN undefined: SHL/SUB/COMMIT and R/Rs/c9 absent; cmd_div port kept but ignored; every command is multiply.

Verification
REQ-029 mul opa=0xFF opb=0xFF, res_ready=1 -> res=0xFE01, res_valid 24 edges after accept.
REQ-030 mul opa=0x0D opb=0x0B -> res=0x008F; then res_ready low 5 cycles -> res_valid and res held 5 cycles.
REQ-031 div (DIV_EN) opa=200 opb=7 -> res=0x041C; opa=0x5A opb=0x00 -> res=0x5AFF.
REQ-032 IDLE, cpu_op=0011 cpu_ai=0x12 cpu_bi=0x34 cpu_rdy=1 -> alu_* equal cpu_*, busy=0; during ADD cpu_* toggling -> alu_* unaffected.
REQ-033 reset pulsed at cycle 10 of a multiply -> IDLE, busy=0, res_valid never asserts; next command opa=3 opb=5 -> res=0x000F.
REQ-034 start held high through a run -> exactly one accept per handshake; without DIV_EN, cmd_div=1 opa=6 opb=7 -> res=0x002A.

Source files
------------

// File: rtl/alu_seq_6502_if.sv
// alu_seq_6502_if: command/result handshake, CPU-side ALU request and the
// shared-ALU drive/return buses around the alu_seq_6502 sequencer.
// slave = sequencer view, master = surrounding CPU/ALU view.
interface alu_seq_6502_if;
   localparam int unsigned DW  = 8;
   localparam int unsigned OPW = 4;

   logic              start;
   logic              start_ready;
   logic              cmd_div;
   logic [DW-1:0]     opa;
   logic [DW-1:0]     opb;
   logic              res_valid;
   logic              res_ready;
   logic [2*DW-1:0]   res;
   logic              busy;

   logic [OPW-1:0]    cpu_op;
   logic              cpu_right;
   logic [DW-1:0]     cpu_ai;
   logic [DW-1:0]     cpu_bi;
   logic              cpu_ci;
   logic              cpu_bcd;
   logic              cpu_rdy;

   logic [OPW-1:0]    alu_op;
   logic              alu_right;
   logic [DW-1:0]     alu_ai;
   logic [DW-1:0]     alu_bi;
   logic              alu_ci;
   logic              alu_bcd;
   logic              alu_rdy;

   logic [DW-1:0]     alu_out;
   logic              alu_co;

   modport slave (
      input  start, cmd_div, opa, opb, res_ready,
      input  cpu_op, cpu_right, cpu_ai, cpu_bi, cpu_ci, cpu_bcd, cpu_rdy,
      input  alu_out, alu_co,
      output start_ready, res_valid, res, busy,
      output alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
   );

   modport master (
      output start, cmd_div, opa, opb, res_ready,
      output cpu_op, cpu_right, cpu_ai, cpu_bi, cpu_ci, cpu_bcd, cpu_rdy,
      output alu_out, alu_co,
      input  start_ready, res_valid, res, busy,
      input  alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
   );
endinterface

// File: rtl/alu_seq_6502.sv
// alu_seq_6502: 8x8 multiply (shift-add) and, when ALU_SEQ_DIV_EN is defined,
// 8/8 restoring divide, sequenced through the shared 6502 ALU (3 cycles per
// iteration, 8 iterations). Outside a run the ALU is handed to the CPU side.
// hi/lo hold P/M for multiply and R/Q for divide; res = {hi,lo}.
module alu_seq_6502 (
   input  logic          clk,
   input  logic          reset,
   alu_seq_6502_if.slave bus
);
   localparam int unsigned DW  = 8;
   localparam int unsigned CW  = 3;
   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_ADD  = 4'b0011;   // ai + bi + ci
   localparam logic [OPW-1:0] OP_PASS = 4'b1111;   // ai (or ror with right)
`ifdef ALU_SEQ_DIV_EN
   localparam logic [OPW-1:0] OP_DBL  = 4'b1011;   // ai + ai + ci
   localparam logic [OPW-1:0] OP_SUB  = 4'b0111;   // ai + ~bi + ci
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_ROR,
      S_SHIFT,
`ifdef ALU_SEQ_DIV_EN
      S_SHL,
      S_SUB,
      S_COMMIT,
`endif
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [DW-1:0]     hi_q, hi_d;
   logic [DW-1:0]     lo_q, lo_d;
   logic [DW-1:0]     b_q, b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*DW-1:0]   res_q, res_d;
   logic              start_ready_q;
   logic              busy_q;
   logic              res_valid_q;
`ifdef ALU_SEQ_DIV_EN
   logic [DW-1:0]     rs_q, rs_d;
   logic              c9_q, c9_d;
   logic              ok_c;
`else
   logic              cmd_div_unused;
   assign cmd_div_unused = bus.cmd_div;
`endif

   logic              seq_c;
   logic              last_c;
   logic [OPW-1:0]    alu_op_c;
   logic              alu_right_c;
   logic [DW-1:0]     alu_ai_c;
   logic [DW-1:0]     alu_bi_c;
   logic              alu_ci_c;
   logic              alu_bcd_c;
   logic              alu_rdy_c;

   assign last_c = &cnt_q;

   // Next state, datapath updates and shared-ALU drive.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
`ifdef ALU_SEQ_DIV_EN
      rs_d    = rs_q;
      c9_d    = c9_q;
      ok_c    = 1'b0;
`endif
      seq_c       = (state_q != S_IDLE) && (state_q != S_DONE);
      alu_op_c    = bus.cpu_op;
      alu_right_c = bus.cpu_right;
      alu_ai_c    = bus.cpu_ai;
      alu_bi_c    = bus.cpu_bi;
      alu_ci_c    = bus.cpu_ci;
      alu_bcd_c   = bus.cpu_bcd;
      alu_rdy_c   = bus.cpu_rdy;
      if (seq_c) begin
         alu_op_c    = OP_PASS;
         alu_right_c = 1'b0;
         alu_ai_c    = hi_q;
         alu_bi_c    = b_q;
         alu_ci_c    = 1'b0;
         alu_bcd_c   = 1'b0;
         alu_rdy_c   = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               b_d   = bus.opb;
               hi_d  = '0;
               lo_d  = bus.opa;
               cnt_d = '0;
`ifdef ALU_SEQ_DIV_EN
               state_d = bus.cmd_div ? S_SHL : S_ADD;
`else
               state_d = S_ADD;
`endif
            end
         end
         S_ADD: begin
            alu_op_c  = lo_q[0] ? OP_ADD : OP_PASS;
            alu_rdy_c = 1'b1;
            state_d   = S_ROR;
         end
         S_ROR: begin
            alu_op_c    = OP_PASS;
            alu_right_c = 1'b1;
            alu_ai_c    = bus.alu_out;
            alu_ci_c    = bus.alu_co;
            alu_rdy_c   = 1'b1;
            state_d     = S_SHIFT;
         end
         S_SHIFT: begin
            hi_d  = bus.alu_out;
            lo_d  = {bus.alu_co, lo_q[DW-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
               state_d = S_DONE;
               res_d   = {hi_d, lo_d};
            end else begin
               state_d = S_ADD;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         S_SHL: begin
            alu_op_c  = OP_DBL;
            alu_ci_c  = lo_q[DW-1];
            alu_rdy_c = 1'b1;
            state_d   = S_SUB;
         end
         S_SUB: begin
            rs_d      = bus.alu_out;
            c9_d      = bus.alu_co;
            alu_op_c  = OP_SUB;
            alu_ai_c  = bus.alu_out;
            alu_ci_c  = 1'b1;
            alu_rdy_c = 1'b1;
            state_d   = S_COMMIT;
         end
         S_COMMIT: begin
            // Ninth bit of the shifted remainder or no borrow means R >= B.
            ok_c  = c9_q | bus.alu_co;
            hi_d  = ok_c ? bus.alu_out : rs_q;
            lo_d  = {lo_q[DW-2:0], ok_c};
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
               state_d = S_DONE;
               res_d   = {hi_d, lo_d};
            end else begin
               state_d = S_SHL;
            end
         end
`endif
         S_DONE: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         hi_q          <= '0;
         lo_q          <= '0;
         b_q           <= '0;
         cnt_q         <= '0;
         res_q         <= '0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         rs_q          <= '0;
         c9_q          <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         b_q           <= b_d;
         cnt_q         <= cnt_d;
         res_q         <= res_d;
         start_ready_q <= (state_d == S_IDLE);
         busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
         res_valid_q   <= (state_d == S_DONE);
`ifdef ALU_SEQ_DIV_EN
         rs_q          <= rs_d;
         c9_q          <= c9_d;
`endif
      end
   end

   assign bus.start_ready = start_ready_q;
   assign bus.busy        = busy_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res         = res_q;
   assign bus.alu_op      = alu_op_c;
   assign bus.alu_right   = alu_right_c;
   assign bus.alu_ai      = alu_ai_c;
   assign bus.alu_bi      = alu_bi_c;
   assign bus.alu_ci      = alu_ci_c;
   assign bus.alu_bcd     = alu_bcd_c;
   assign bus.alu_rdy     = alu_rdy_c;
endmodule

// File: tb/tb_alu_seq_6502.sv
// tb_alu_seq_6502: directed vectors for alu_seq_6502 with a behavioural
// registered 6502 ALU on the shared-ALU side.
module tb_alu_seq_6502;
   logic clk   = 1'b0;
   logic reset = 1'b1;

   alu_seq_6502_if bus ();

   alu_seq_6502 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        div;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
      string       name;
   } vec_t;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int acc_cnt   = 0;
   int hs_cnt    = 0;
   int rv_cnt    = 0;

   // 6502 ALU: op[1:0] picks the logic term, op[3:2] the adder B input.
   function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic right,
                                         input logic [7:0] ai, input logic [7:0] bi,
                                         input logic ci);
      logic [8:0] lg;
      logic [7:0] bsel;
      logic       cin;
      case (op[1:0])
         2'b00:   lg = {1'b0, ai | bi};
         2'b01:   lg = {1'b0, ai & bi};
         2'b10:   lg = {1'b0, ai ^ bi};
         default: lg = {1'b0, ai};
      endcase
      if (right) lg = {ai[0], ci, ai[7:1]};
      case (op[3:2])
         2'b00:   bsel = bi;
         2'b01:   bsel = ~bi;
         2'b10:   bsel = lg[7:0];
         default: bsel = 8'h00;
      endcase
      cin = (right || (op[3:2] == 2'b11)) ? 1'b0 : ci;
      return lg + {1'b0, bsel} + {8'h00, cin};
   endfunction

   // Registered shared ALU.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.alu_out <= 8'h00;
         bus.alu_co  <= 1'b0;
      end else if (bus.alu_rdy) begin
         {bus.alu_co, bus.alu_out} <= alu_fn(bus.alu_op, bus.alu_right, bus.alu_ai,
                                             bus.alu_bi, bus.alu_ci);
      end
   end

   // Handshake event counters.
   always @(posedge clk) begin
      if (!reset) begin
         if (bus.start && bus.start_ready)   acc_cnt++;
         if (bus.res_valid && bus.res_ready) hs_cnt++;
         if (bus.res_valid)                  rv_cnt++;
      end
   end

   function automatic logic [23:0] alu_pack();
      return {bus.alu_op, bus.alu_right, bus.alu_ai, bus.alu_bi,
              bus.alu_ci, bus.alu_bcd, bus.alu_rdy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Present one command; returns 1ns after the accepting edge.
   task automatic launch(input logic div, input logic [7:0] a, input logic [7:0] b);
      int g;
      g = 0;
      while (bus.start_ready !== 1'b1 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      check("launch_ready", 32'(bus.start_ready), 32'd1);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.cmd_div = div;
      bus.opa     = a;
      bus.opb     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Count edges from the accepting edge until res_valid; note busy drops.
   task automatic wait_result(output int n, output int bad_busy);
      n = 0;
      bad_busy = 0;
      while (bus.res_valid !== 1'b1 && n < 40) begin
         if (bus.busy !== 1'b1) bad_busy++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      int   n;
      int   bb;
      int   g;
      int   a0;
      int   h0;
      int   r0;
      vec_t vecs[$];

      bus.start     = 1'b0;
      bus.cmd_div   = 1'b0;
      bus.opa       = 8'h00;
      bus.opb       = 8'h00;
      bus.res_ready = 1'b1;
      bus.cpu_op    = 4'h0;
      bus.cpu_right = 1'b0;
      bus.cpu_ai    = 8'h00;
      bus.cpu_bi    = 8'h00;
      bus.cpu_ci    = 1'b0;
      bus.cpu_bcd   = 1'b0;
      bus.cpu_rdy   = 1'b0;

      vecs.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01, "mul_ff_ff"});
      vecs.push_back('{1'b0, 8'h0D, 8'h0B, 16'h008F, "mul_0d_0b"});
      vecs.push_back('{1'b0, 8'h03, 8'h05, 16'h000F, "mul_03_05"});
      vecs.push_back('{1'b0, 8'h00, 8'h7F, 16'h0000, "mul_00_7f"});
      vecs.push_back('{1'b0, 8'h80, 8'h02, 16'h0100, "mul_80_02"});
      vecs.push_back('{1'b0, 8'hC8, 8'h64, 16'h4E20, "mul_c8_64"});
      vecs.push_back('{1'b0, 8'h01, 8'hFF, 16'h00FF, "mul_01_ff"});
`ifdef ALU_SEQ_DIV_EN
      vecs.push_back('{1'b1, 8'hC8, 8'h07, 16'h041C, "div_200_7"});
      vecs.push_back('{1'b1, 8'h5A, 8'h00, 16'h5AFF, "div_by_zero"});
      vecs.push_back('{1'b1, 8'h06, 8'h07, 16'h0600, "div_6_7"});
      vecs.push_back('{1'b1, 8'hFF, 8'h10, 16'h0F0F, "div_ff_10"});
`else
      vecs.push_back('{1'b1, 8'h06, 8'h07, 16'h002A, "nodiv_6_7"});
`endif

      // Reset values, during and after reset.
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",      32'(bus.busy),        32'd0);
      check("rst_res_valid", 32'(bus.res_valid),   32'd0);
      check("rst_res",       32'(bus.res),         32'h0000);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_start_ready", 32'(bus.start_ready), 32'd1);
      check("post_rst_busy",        32'(bus.busy),        32'd0);

      // CPU pass-through while idle.
      bus.cpu_op  = 4'b0011;
      bus.cpu_ai  = 8'h12;
      bus.cpu_bi  = 8'h34;
      bus.cpu_ci  = 1'b1;
      bus.cpu_bcd = 1'b1;
      bus.cpu_rdy = 1'b1;
      #1;
      check("idle_passthru", 32'(alu_pack()),
            32'({4'b0011, 1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1}));
      bus.cpu_rdy = 1'b0;
      bus.cpu_bcd = 1'b0;

      // 0x0D*0x0B with CPU noise while busy, then a 5-cycle result stall.
      bus.res_ready = 1'b0;
      launch(1'b0, 8'h0D, 8'h0B);
      bus.cpu_op    = 4'h5;
      bus.cpu_right = 1'b1;
      bus.cpu_ai    = 8'hAA;
      bus.cpu_bi    = 8'h55;
      bus.cpu_ci    = 1'b1;
      bus.cpu_bcd   = 1'b1;
      bus.cpu_rdy   = 1'b0;
      #1;
      check("add_drive", 32'(alu_pack()),
            32'({4'b0011, 1'b0, 8'h00, 8'h0B, 1'b0, 1'b0, 1'b1}));
      fork
         wait_result(n, bb);
         repeat (20) begin
            @(negedge clk);
            bus.cpu_op    = 4'($urandom);
            bus.cpu_right = 1'($urandom);
            bus.cpu_ai    = 8'($urandom);
            bus.cpu_bi    = 8'($urandom);
            bus.cpu_ci    = 1'($urandom);
            bus.cpu_bcd   = 1'($urandom);
            bus.cpu_rdy   = 1'($urandom);
         end
      join
      bus.cpu_rdy = 1'b0;
      bus.cpu_bcd = 1'b0;
      check("stall_latency",  32'(n),        32'd24);
      check("stall_busy_run", 32'(bb),       32'd0);
      check("stall_res",      32'(bus.res),  32'h008F);
      check("stall_done_busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("stall_hold_valid", 32'(bus.res_valid), 32'd1);
         check("stall_hold_res",   32'(bus.res),       32'h008F);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_valid", 32'(bus.res_valid),   32'd0);
      check("stall_release_ready", 32'(bus.start_ready), 32'd1);
      check("stall_release_res",   32'(bus.res),         32'h008F);

      // Vector table.
      foreach (vecs[i]) begin
         launch(vecs[i].div, vecs[i].a, vecs[i].b);
         wait_result(n, bb);
         check({vecs[i].name, "_latency"}, 32'(n),        32'd24);
         check({vecs[i].name, "_busy"},    32'(bb),       32'd0);
         check({vecs[i].name, "_res"},     32'(bus.res),  32'(vecs[i].exp));
         check({vecs[i].name, "_done_busy"}, 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
         check({vecs[i].name, "_after_valid"}, 32'(bus.res_valid), 32'd0);
         check({vecs[i].name, "_after_res"},   32'(bus.res),       32'(vecs[i].exp));
      end

      // start held high across two runs: one accept per handshake.
      a0 = acc_cnt;
      h0 = hs_cnt;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.cmd_div = 1'b0;
      bus.opa     = 8'h03;
      bus.opb     = 8'h05;
      g = 0;
      while ((hs_cnt - h0) < 2 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check("held_handshakes", 32'(hs_cnt - h0),  32'd2);
      check("held_accepts",    32'(acc_cnt - a0), 32'd2);
      check("held_res",        32'(bus.res),      32'h000F);

      // Reset in the middle of a multiply.
      r0 = rv_cnt;
      launch(1'b0, 8'hC8, 8'h64);
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy",        32'(bus.busy),        32'd0);
      check("abort_res_valid",   32'(bus.res_valid),   32'd0);
      check("abort_start_ready", 32'(bus.start_ready), 32'd1);
      check("abort_res",         32'(bus.res),         32'h0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_valid", 32'(rv_cnt - r0), 32'd0);
      check("abort_idle_busy", 32'(bus.busy),   32'd0);
      launch(1'b0, 8'h03, 8'h05);
      wait_result(n, bb);
      check("after_abort_latency", 32'(n),       32'd24);
      check("after_abort_res",     32'(bus.res), 32'h000F);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
